// File: rtl/tns_pkg.sv
`default_nettype none
//==============================================================================
// Module      : tns_pkg
// Description : TNS group weight tables and width/range helper functions.
// Revision    : 1.0 - initial release
//==============================================================================
package tns_pkg;

    localparam int TNS_GW     = 3;
    localparam int TNS_GROUPS = 16;

    // Weights of group g are 3L, 2L, L with L = 7^g, i.e. the value range of all lower groups.
    localparam logic [63:0] TNS_C [TNS_GROUPS] = '{
        64'd1,            64'd7,             64'd49,             64'd343,
        64'd2401,         64'd16807,         64'd117649,         64'd823543,
        64'd5764801,      64'd40353607,      64'd282475249,      64'd1977326743,
        64'd13841287201,  64'd96889010407,   64'd678223072849,   64'd4747561509943
    };

    localparam logic [63:0] TNS_B [TNS_GROUPS] = '{
        64'd2,            64'd14,            64'd98,             64'd686,
        64'd4802,         64'd33614,         64'd235298,         64'd1647086,
        64'd11529602,     64'd80707214,      64'd564950498,      64'd3954653486,
        64'd27682574402,  64'd193778020814,  64'd1356446145698,  64'd9495123019886
    };

    localparam logic [63:0] TNS_A [TNS_GROUPS] = '{
        64'd3,            64'd21,            64'd147,            64'd1029,
        64'd7203,         64'd50421,         64'd352947,         64'd2470629,
        64'd17294403,     64'd121060821,     64'd847425747,      64'd5931980229,
        64'd41523861603,  64'd290667031221,  64'd2034669218547,  64'd14242684529829
    };

    // Number of encodable values with n groups: one more than the sum of all their weights.
    function automatic logic [63:0] TNS_MAX(input int n);
        logic [63:0] m;
        m = 64'd1;
        for (int i = 0; i < n && i < TNS_GROUPS; i++) begin
            m = m + TNS_A[i] + TNS_B[i] + TNS_C[i];
        end
        return m;
    endfunction

    function automatic int TNS_BLEN(input int n);
        logic [63:0] m;
        int          b;
        m = TNS_MAX(n) - 64'd1;
        b = 1;
        for (int i = 0; i < 64; i++) begin
            if (m[i]) b = i + 1;
        end
        return b;
    endfunction

endpackage : tns_pkg
`default_nettype wire

// File: rtl/tns_group_stage.sv
`default_nettype none
//==============================================================================
// Module      : tns_group_stage
// Description : One pipeline stage: registers a word, encodes its TNS group.
// Revision    : 1.0 - initial release
//==============================================================================
module tns_group_stage
    import tns_pkg::*;
#(
    parameter int   G_IDX     = 0,
    parameter int   GROUPS    = 4,
    parameter int   DIN_W     = 12,
    parameter logic HIST_INIT = 1'b0
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     hist_clr,
    input  logic                     up_valid,
    input  logic [DIN_W-1:0]         up_rem,
    input  logic [TNS_GW*GROUPS-1:0] up_code,
    input  logic                     up_err,
    output logic                     up_ready,
    input  logic                     dn_ready,
    output logic                     dn_valid,
    output logic [DIN_W-1:0]         dn_rem,
    output logic [TNS_GW*GROUPS-1:0] dn_code,
    output logic                     dn_err
);

    localparam logic [DIN_W:0] WA  = (DIN_W+1)'(TNS_A[G_IDX]);
    localparam logic [DIN_W:0] WB  = (DIN_W+1)'(TNS_B[G_IDX]);
    localparam logic [DIN_W:0] WC  = (DIN_W+1)'(TNS_C[G_IDX]);
    localparam logic [DIN_W:0] WAC = WA + WC;

    logic                     valid;
    logic                     err;
    logic                     hist;
    logic [DIN_W-1:0]         rem;
    logic [TNS_GW*GROUPS-1:0] code;

    logic                     bit_a;
    logic                     bit_b;
    logic                     bit_c;
    logic [DIN_W:0]           r0;
    logic [DIN_W:0]           r1;
    logic [DIN_W:0]           r2;
    logic                     adv;

    assign adv      = valid && dn_ready;
    assign up_ready = !valid || dn_ready;
    assign dn_valid = valid;
    assign dn_err   = err;

    // Inside [A, A+C) both choices of bit A decode to the same value; history picks one.
    always_comb begin
        r0 = {1'b0, rem};
        if (r0 >= WAC) begin
            bit_a = 1'b1;
        end else if (r0 < WA) begin
            bit_a = 1'b0;
        end else begin
            bit_a = hist;
        end
        r1     = bit_a ? (r0 - WA) : r0;
        bit_b  = (r1 >= WB);
        r2     = bit_b ? (r1 - WB) : r1;
        bit_c  = (r2 >= WC);
        dn_rem = bit_c ? DIN_W'(r2 - WC) : DIN_W'(r2);
    end

    always_comb begin
        dn_code = code;
        dn_code[TNS_GW*G_IDX +: TNS_GW] = {bit_a, bit_b, bit_c};
        if (err) begin
            dn_code = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            rem   <= '0;
            code  <= '0;
            err   <= 1'b0;
            hist  <= HIST_INIT;
        end else begin
            if (up_ready) begin
                valid <= up_valid;
                if (up_valid) begin
                    rem  <= up_rem;
                    code <= up_code;
                    err  <= up_err;
                end
            end
            if (hist_clr) begin
                hist <= HIST_INIT;
            end else if (adv && !err) begin
                hist <= bit_a;
            end
        end
    end

endmodule : tns_group_stage
`default_nettype wire

// File: rtl/tns_pipe_encoder.sv
`default_nettype none
//==============================================================================
// Module      : tns_pipe_encoder
// Description : Pipelined GROUPS x 3-bit TNS encoder, valid/ready on both sides.
//               Define TNS_RANGE_CHK_EN to add the out_err range-check port.
// Revision    : 1.0 - initial release
//==============================================================================
module tns_pipe_encoder
    import tns_pkg::*;
#(
    parameter int   GROUPS    = 4,
    parameter int   DIN_W     = tns_pkg::TNS_BLEN(GROUPS),
    parameter logic HIST_INIT = 1'b0
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     hist_clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIN_W-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef TNS_RANGE_CHK_EN
    output logic                     out_err,
`endif
    output logic [TNS_GW*GROUPS-1:0] out_code
);

    localparam int CW = TNS_GW * GROUPS;

    // Index GROUPS is the input side, index 0 the output side.
    logic             v_c    [GROUPS+1];
    logic             rdy_c  [GROUPS+1];
    logic [DIN_W-1:0] rem_c  [GROUPS+1];
    logic [CW-1:0]    code_c [GROUPS+1];
    logic             err_c  [GROUPS+1];

    assign v_c[GROUPS]    = in_valid;
    assign rem_c[GROUPS]  = in_data;
    assign code_c[GROUPS] = '0;
    assign rdy_c[0]       = out_ready;
    assign in_ready       = rdy_c[GROUPS];
    assign out_valid      = v_c[0];
    assign out_code       = code_c[0];

`ifdef TNS_RANGE_CHK_EN
    assign err_c[GROUPS]  = (64'(in_data) >= TNS_MAX(GROUPS));
    assign out_err        = err_c[0];
`else
    assign err_c[GROUPS]  = 1'b0;
`endif

    for (genvar g = 0; g < GROUPS; g++) begin : g_stage
        tns_group_stage #(
            .G_IDX     (g),
            .GROUPS    (GROUPS),
            .DIN_W     (DIN_W),
            .HIST_INIT (HIST_INIT)
        ) u_stage (
            .clock    (clock),
            .rst_n    (rst_n),
            .hist_clr (hist_clr),
            .up_valid (v_c[g+1]),
            .up_rem   (rem_c[g+1]),
            .up_code  (code_c[g+1]),
            .up_err   (err_c[g+1]),
            .up_ready (rdy_c[g+1]),
            .dn_ready (rdy_c[g]),
            .dn_valid (v_c[g]),
            .dn_rem   (rem_c[g]),
            .dn_code  (code_c[g]),
            .dn_err   (err_c[g])
        );
    end

endmodule : tns_pipe_encoder
`default_nettype wire

// File: tb/tb_tns_pipe_encoder.sv
`default_nettype none
//==============================================================================
// Module      : tb_tns_pipe_encoder
// Description : Scoreboard bench for tns_pipe_encoder with a base-7 digit model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_tns_pipe_encoder;
    import tns_pkg::*;

    localparam int              G    = 4;
    localparam int              DW   = TNS_BLEN(G);
    localparam int              CW   = TNS_GW * G;
    localparam logic            HI   = 1'b0;
    localparam longint unsigned MAXV = TNS_MAX(G);

    logic          clock;
    logic          rst_n;
    logic          hist_clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_code;
`ifdef TNS_RANGE_CHK_EN
    logic          out_err;
`endif

    tns_pipe_encoder #(
        .GROUPS    (G),
        .HIST_INIT (HI)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .hist_clr  (hist_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef TNS_RANGE_CHK_EN
        .out_err   (out_err),
`endif
        .out_code  (out_code)
    );

    typedef struct {
        logic [CW-1:0]   code;
        logic            err;
        longint unsigned data;
        int              acc;
        bit              lat;
    } exp_t;

    exp_t            q [$];
    logic [CW-1:0]   got_codes [$];
    logic            got_errs [$];
    int              got_cyc [$];
    logic            m_hist [G];
    int              n_chk;
    int              n_err;
    int              cyc;
    bit              rand_ordy;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each group carries one base-7 digit d; only d==3 has two spellings (100 or 011).
    function automatic logic [CW-1:0] model_encode(input longint unsigned x);
        logic [CW-1:0]   c;
        longint unsigned p;
        int              d;
        logic [2:0]      grp;
        c = '0;
        p = 1;
        for (int g = 0; g < G; g++) begin
            d = int'((x / p) % 64'd7);
            case (d)
                0:       grp = 3'b000;
                1:       grp = 3'b001;
                2:       grp = 3'b010;
                3:       grp = m_hist[g] ? 3'b100 : 3'b011;
                4:       grp = 3'b101;
                5:       grp = 3'b110;
                default: grp = 3'b111;
            endcase
            c[TNS_GW*g +: TNS_GW] = grp;
            m_hist[g] = grp[2];
            p = p * 7;
        end
        return c;
    endfunction

    function automatic longint unsigned decode(input logic [CW-1:0] c);
        longint unsigned s;
        longint unsigned p;
        s = 0;
        p = 1;
        for (int g = 0; g < G; g++) begin
            s = s + (64'(c[TNS_GW*g+2]) * 3 + 64'(c[TNS_GW*g+1]) * 2 + 64'(c[TNS_GW*g])) * p;
            p = p * 7;
        end
        return s;
    endfunction

    function automatic logic [63:0] got_code(input int i);
        if (i >= 0 && i < got_codes.size()) return 64'(got_codes[i]);
        return 'x;
    endfunction

    function automatic logic [63:0] got_cycle(input int i);
        if (i >= 0 && i < got_cyc.size()) return 64'(got_cyc[i]);
        return 'x;
    endfunction

    task automatic push(input longint unsigned x, input bit lat);
        exp_t e;
        e.data = x;
        e.acc  = cyc;
        e.lat  = lat;
        if (x >= MAXV) begin
            e.code = '0;
            e.err  = 1'b1;
        end else begin
            e.code = model_encode(x);
            e.err  = 1'b0;
        end
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send(input longint unsigned x, input bit lat);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = DW'(x);
        @(negedge clock);
        while (!in_ready && n < 200) begin
            step();
            @(negedge clock);
            n++;
        end
        if (in_ready) begin
            push(x, lat);
        end else begin
            chk("send_timeout", 64'(in_ready), 64'd1);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 1000) begin
            step();
            n++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
    endtask

    task automatic reset_model();
        for (int g = 0; g < G; g++) m_hist[g] = HI;
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
    end

    initial forever begin
        exp_t e;
        @(negedge clock);
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("out_code", 64'(out_code), 64'(q[0].code));
`ifdef TNS_RANGE_CHK_EN
                chk("out_err", 64'(out_err), 64'(q[0].err));
`endif
                if (out_ready) begin
                    e = q.pop_front();
                    if (!e.err) chk("decode", decode(out_code), e.data);
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd4);
                    got_codes.push_back(out_code);
                    got_cyc.push_back(cyc);
`ifdef TNS_RANGE_CHK_EN
                    got_errs.push_back(out_err);
`else
                    got_errs.push_back(1'b0);
`endif
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            base;
        int            acc;
        logic [63:0]   t;
        longint unsigned x;
        int            idle;

        n_chk     = 0;
        n_err     = 0;
        rand_ordy = 1'b0;
        rst_n     = 1'b0;
        hist_clr  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        reset_model();

        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_code", 64'(out_code), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // Single zero word: latency and all-zero code.
        base = got_codes.size();
        send(0, 1'b1);
        drain();
        chk("zero_code", got_code(base), 64'd0);

        // 16 back-to-back words at one per cycle.
        base = got_codes.size();
        for (int i = 0; i < 16; i++) send(longint'(i), 1'b0);
        drain();
        chk("b2b_spacing", got_cycle(base + 15) - got_cycle(base), 64'd15);

        // Ambiguous range with group-3 history set, then after hist_clr.
        base = got_codes.size();
        send(1372, 1'b0);
        send(1029, 1'b0);
        drain();
        t = got_code(base + 1);
        chk("amb_hist1_bit11", 64'(t[11]), 64'd1);
        hist_clr = 1'b1;
        step();
        hist_clr = 1'b0;
        reset_model();
        base = got_codes.size();
        send(1029, 1'b0);
        drain();
        t = got_code(base);
        chk("amb_clr_bit11", 64'(t[11]), 64'd0);

        // Backpressure: four stages fill, then in_ready drops.
        out_ready = 1'b0;
        acc       = 0;
        x         = longint'($urandom_range(0, 2400));
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(x);
            @(negedge clock);
            if (i >= 4) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (in_ready) begin
                push(x, 1'b0);
                acc++;
                x = longint'($urandom_range(0, 2400));
            end
            step();
        end
        in_valid  = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd4);
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with three words in flight.
        out_ready = 1'b0;
        send(1372, 1'b0);
        send(5, 1'b0);
        send(100, 1'b0);
        step();
        step();
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        q.delete();
        reset_model();
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_code", 64'(out_code), 64'd0);
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) step();
        base = got_codes.size();
        send(1029, 1'b0);
        drain();
        t = got_code(base);
        chk("post_rst_hist_bit11", 64'(t[11]), 64'(HI));

`ifdef TNS_RANGE_CHK_EN
        base = got_codes.size();
        send(1372, 1'b0);
        send(MAXV, 1'b0);
        send(1029, 1'b0);
        drain();
        chk("range_code_zero", got_code(base + 1), 64'd0);
        chk("range_err_set", (base + 1 < got_errs.size()) ? 64'(got_errs[base + 1]) : 'x, 64'd1);
        t = got_code(base + 2);
        chk("range_keeps_hist", 64'(t[11]), 64'd1);
`endif

        // Randomized traffic with random backpressure and gaps.
        rand_ordy = 1'b1;
        repeat (300) begin
            idle = int'($urandom_range(0, 3));
            if (idle > 1) repeat (idle - 1) step();
`ifdef TNS_RANGE_CHK_EN
            if ($urandom_range(0, 15) == 0) x = longint'($urandom_range(2401, 4095));
            else                            x = longint'($urandom_range(0, 2400));
`else
            x = longint'($urandom_range(0, 2400));
`endif
            send(x, 1'b0);
        end
        rand_ordy = 1'b0;
        step();
        out_ready = 1'b1;
        drain();
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_tns_pipe_encoder
`default_nettype wire
